// File: rtl/game_pkg.sv
// Shared definitions for the object RAM record layout,
// sprite colours, screen bounds and frame timing.
package game_pkg;

  localparam int FRAME_CLOCK = 833_334;
  localparam int MAX_OBJ     = 16;
  localparam int SPRITE      = 16;
  localparam int SCREEN_W    = 320;
  localparam int SCREEN_H    = 240;

  localparam logic [2:0] BG_COLOUR   = 3'b000;
  localparam logic [2:0] COL_STONE   = 3'b111;
  localparam logic [2:0] COL_GOLD    = 3'b110;
  localparam logic [2:0] COL_DIAMOND = 3'b011;

  localparam int X_HI = 31;
  localparam int X_LO = 23;
  localparam int Y_HI = 18;
  localparam int Y_LO = 11;
  localparam int T_HI = 3;
  localparam int T_LO = 2;
  localparam int VIS_BIT = 1;
  localparam int MOV_BIT = 0;

  typedef enum logic [1:0] {
    T_STONE   = 2'b00,
    T_GOLD    = 2'b01,
    T_DIAMOND = 2'b10,
    T_DIAM_B  = 2'b11
  } obj_type_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_ADDR,
    S_READ_WAIT,
    S_LATCH,
    S_ERASE,
    S_DRAW,
    S_NEXT
  } draw_state_t;

  typedef struct packed {
    logic [8:0] x;
    logic [3:0] pad_a;
    logic [7:0] y;
    logic [6:0] pad_b;
    logic [1:0] kind;
    logic       vis;
    logic       mov;
  } rec_t;

  function automatic logic [2:0] type_colour(
    input logic [1:0] t
  );
    logic [2:0] c;
    c = COL_DIAMOND;
    unique case (1'b1)
      (t == T_STONE): c = COL_STONE;
      (t == T_GOLD):  c = COL_GOLD;
      default:        c = COL_DIAMOND;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/stone_drawer_if.sv
// Bus between the stone drawer and its RAM/VGA
// neighbours; the drawer is the master side.
interface stone_drawer_if;

  logic        enable;
  logic [3:0]  quantity;
  logic [31:0] data;
  logic        draw_stone_flag;
  logic [3:0]  draw_index;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  colour;
  logic        plot;

  modport master (
    input  enable,
    input  quantity,
    input  data,
    output draw_stone_flag,
    output draw_index,
    output vga_x,
    output vga_y,
    output colour,
    output plot
  );

  modport slave (
    output enable,
    output quantity,
    output data,
    input  draw_stone_flag,
    input  draw_index,
    input  vga_x,
    input  vga_y,
    input  colour,
    input  plot
  );

endinterface

// File: rtl/sprite_scan.sv
// 16x16 row-major pixel walker shared by the
// erase and draw phases; done marks the 256th pixel.
module sprite_scan (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [3:0] col,
  output logic [3:0] row
);

  logic [7:0] count;

  assign done = busy && (count == 8'hff);
  assign col  = count[3:0];
  assign row  = count[7:4];

  // restart from pixel 0 on start, else step while busy
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      count <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      count <= count + 8'd1;
      if (count == 8'hff)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/stone_drawer.sv
// Per-frame walk of the stone records: erase each old
// sprite, redraw visible stones as VGA plot requests.
module stone_drawer
  import game_pkg::*;
#(
  parameter int FRAME_CLOCK = game_pkg::FRAME_CLOCK
) (
  input logic            clock,
  input logic            reset,
  stone_drawer_if.master bus
);

  localparam int FW =
    (FRAME_CLOCK > 2) ? $clog2(FRAME_CLOCK) : 1;

  draw_state_t state;
  draw_state_t state_nx;

  logic [FW-1:0] frame_cnt;
  logic          frame_last;

  logic       flag;
  logic [3:0] index;
  logic       plot_r;
  logic [8:0] x_r;
  logic [7:0] y_r;
  logic [2:0] col_r;

  rec_t       rd;
  logic [8:0] cur_x;
  logic [7:0] cur_y;
  logic [1:0] cur_kind;
  logic       cur_vis;

  logic [8:0]         sh_x [MAX_OBJ];
  logic [7:0]         sh_y [MAX_OBJ];
  logic [MAX_OBJ-1:0] sh_v;

  logic       scan_start;
  logic       scan_busy;
  logic       scan_done;
  logic [3:0] scan_col;
  logic [3:0] scan_row;

  logic pass_start;
  logic pass_end;
  logic idx_inc;
  logic sh_store;
  logic sh_clear;

  logic       scanning;
  logic [8:0] base_x;
  logic [7:0] base_y;
  logic [9:0] px;
  logic [9:0] py;
  logic       on_screen;
  logic       unused;

  assign rd     = bus.data;
  assign unused = ^{rd.pad_a, rd.pad_b, rd.mov};

  assign frame_last =
    (frame_cnt == FW'(FRAME_CLOCK - 1));

  sprite_scan u_scan (
    .clock (clock),
    .reset (reset),
    .start (scan_start),
    .busy  (scan_busy),
    .done  (scan_done),
    .col   (scan_col),
    .row   (scan_row)
  );

  // state register
  always_ff @(posedge clock) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  // next state and per-cycle control strobes
  always_comb begin
    state_nx   = state;
    scan_start = 1'b0;
    pass_start = 1'b0;
    pass_end   = 1'b0;
    idx_inc    = 1'b0;
    sh_store   = 1'b0;
    sh_clear   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.enable)
          state_nx = S_WAIT_FRAME;
      end
      S_WAIT_FRAME: begin
        if (!bus.enable) begin
          state_nx = S_IDLE;
        end else if (frame_last) begin
          pass_start = 1'b1;
          state_nx   = S_NEXT;
        end
      end
      S_NEXT: begin
        if (index >= bus.quantity) begin
          pass_end = 1'b1;
          state_nx = S_WAIT_FRAME;
        end else begin
          state_nx = S_ADDR;
        end
      end
      S_ADDR:      state_nx = S_READ_WAIT;
      S_READ_WAIT: state_nx = S_LATCH;
      S_LATCH: begin
        if (sh_v[index]) begin
          scan_start = 1'b1;
          state_nx   = S_ERASE;
        end else if (rd.vis) begin
          scan_start = 1'b1;
          state_nx   = S_DRAW;
        end else begin
          idx_inc  = 1'b1;
          state_nx = S_NEXT;
        end
      end
      S_ERASE: begin
        if (scan_done) begin
          if (cur_vis) begin
            scan_start = 1'b1;
            state_nx   = S_DRAW;
          end else begin
            sh_clear = 1'b1;
            idx_inc  = 1'b1;
            state_nx = S_NEXT;
          end
        end
      end
      S_DRAW: begin
        if (scan_done) begin
          sh_store = 1'b1;
          idx_inc  = 1'b1;
          state_nx = S_NEXT;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // frame counter runs from idle exit, holds at the top
  always_ff @(posedge clock) begin
    if (reset || state == S_IDLE || pass_start)
      frame_cnt <= '0;
    else if (!frame_last)
      frame_cnt <= frame_cnt + 1'b1;
  end

  // pass flag, record index, latched record, valid bits
  always_ff @(posedge clock) begin
    if (reset) begin
      flag     <= 1'b0;
      index    <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      cur_kind <= '0;
      cur_vis  <= 1'b0;
      sh_v     <= '0;
    end else begin
      if (pass_start) begin
        flag  <= 1'b1;
        index <= '0;
      end
      if (pass_end)
        flag <= 1'b0;
      if (idx_inc)
        index <= index + 4'd1;
      if (state == S_LATCH) begin
        cur_x    <= rd.x;
        cur_y    <= rd.y;
        cur_kind <= rd.kind;
        cur_vis  <= rd.vis;
      end
      if (sh_store)
        sh_v[index] <= 1'b1;
      if (sh_clear)
        sh_v[index] <= 1'b0;
    end
  end

  // shadow position of what is currently on screen
  always_ff @(posedge clock) begin
    if (sh_store) begin
      sh_x[index] <= cur_x;
      sh_y[index] <= cur_y;
    end
  end

  assign scanning = scan_busy &&
    (state == S_ERASE || state == S_DRAW);
  assign base_x = (state == S_ERASE) ?
    sh_x[index] : cur_x;
  assign base_y = (state == S_ERASE) ?
    sh_y[index] : cur_y;
  assign px = {1'b0, base_x} + {6'b0, scan_col};
  assign py = {2'b0, base_y} + {6'b0, scan_row};
  assign on_screen = (px < 10'(SCREEN_W)) &&
                     (py < 10'(SCREEN_H));

  // registered pixel strobe; off-screen slots skip plot
  always_ff @(posedge clock) begin
    if (reset) begin
      plot_r <= 1'b0;
      x_r    <= '0;
      y_r    <= '0;
      col_r  <= '0;
    end else begin
      plot_r <= scanning && on_screen;
      if (scanning) begin
        x_r   <= px[8:0];
        y_r   <= py[7:0];
        col_r <= (state == S_ERASE) ?
          BG_COLOUR : type_colour(cur_kind);
      end
    end
  end

  assign bus.draw_stone_flag = flag;
  assign bus.draw_index      = index;
  assign bus.vga_x           = x_r;
  assign bus.vga_y           = y_r;
  assign bus.colour          = col_r;
  assign bus.plot            = plot_r;

endmodule

// File: doc/stone_drawer.md
# stone_drawer

Read-side companion to the rope controller on the shared object RAM. Once per frame it walks the stone records, erases each stone's previously drawn 16×16 sprite and redraws visible stones at their current position as single-pixel VGA plot requests. It holds `draw_stone_flag` high for the whole pass, so the rope FSM never writes the RAM mid-pass. While the flag is high, it owns the RAM read address through `draw_index`.

## Interface
- `FRAME_CLOCK`, 833_334: cycles between pass starts.
- `MAX_OBJ`, 16: number of record slots; `quantity` ≤ `MAX_OBJ`.
- `SPRITE`, 16: sprite edge in pixels.
- `BG_COLOUR`, 3'b000: erase colour.
- `clock`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  allow new passes to start.
- `quantity`  in  4  number of valid records, indices 0..quantity-1.
- `data`  in  32  RAM q for `draw_index`; layout: x[31:23], y[18:11], type[3:2], visible[1], moving[0].
- `draw_stone_flag`  out  1  pass in progress; RAM read address = `draw_index`.
- `draw_index`  out  4  record being read.
- `vga_x`  out  9  pixel x.
- `vga_y`  out  8  pixel y.
- `colour`  out  3  pixel colour.
- `plot`  out  1  one-cycle pixel write strobe; x/y/colour valid while high.

## Operation
- States: S_IDLE, S_WAIT_FRAME, S_ADDR, S_READ_WAIT, S_LATCH, S_ERASE, S_DRAW, S_NEXT.
- Reset: all outputs 0; frame counter 0; shadow valid bits cleared; state S_IDLE.
- S_IDLE → S_WAIT_FRAME when `enable`=1.
- S_WAIT_FRAME: frame counter increments each cycle.
  - At `FRAME_CLOCK`-1 it clears, sets `draw_stone_flag`=1, sets `draw_index`=0, goes to S_NEXT.
  - If `enable`=0, it returns to S_IDLE instead.
- S_NEXT:
  - If `draw_index` ≥ `quantity`: flag=0, go to S_WAIT_FRAME.
  - Otherwise go to S_ADDR.
- S_ADDR → S_READ_WAIT → S_LATCH: the RAM has a 2-cycle read latency. `data` is sampled in S_LATCH.
- S_LATCH checks the shadow entry for this index:
  - If the entry is valid, go to S_ERASE at the old x/y.
  - Otherwise go to S_DRAW if visible=1.
  - Otherwise increment `draw_index` and go to S_NEXT.
- S_ERASE: scan 256 pixels, row-major, in `BG_COLOUR`.
  - Then S_DRAW if visible=1.
  - Otherwise clear the shadow valid bit, increment index, go to S_NEXT.
- S_DRAW: scan 256 pixels in the type colour: 00 stone 3'b111, 01 gold 3'b110, 10/11 diamond 3'b011.
  - Then store shadow x/y with valid=1, increment index, go to S_NEXT.
- The moving bit is ignored; moving stones draw at their current x/y.
- Clipping: pixel address = base + offset, computed 10 bits wide.
  - A pixel with x ≥ 320 or y ≥ 240 is skipped: `plot`=0 for that slot, scan still advances.
- The erase-then-draw order is fixed. A stream with a stationary stone redraws it with no net change.
- `enable` falling mid-pass: the pass completes, then S_IDLE.
- `reset` mid-pass: abort on the next edge; `plot` and flag are 0 after that edge.
- `quantity` is sampled only in S_NEXT; a change mid-pass affects the remaining comparisons.

## Timing
- One pixel per cycle during scans; `plot` is registered.
- Per-record cost:
  - 4 cycles when the record draws nothing.
  - +256 cycles with erase.
  - +256 cycles with draw.
  - Worst case 516 cycles; 16 records ≤ 8257 cycles per pass, far below `FRAME_CLOCK`.
- `quantity`=0: `draw_stone_flag` is high for exactly 1 cycle per pass.
- `draw_stone_flag` rises on the same edge that `draw_index` becomes 0. It falls on the edge after the final S_NEXT compare.

## Structure
- Shared package `game_pkg`:
  - Record field positions.
  - Type codes and type colours.
  - `BG_COLOUR`, screen bounds 320/240, `FRAME_CLOCK`.
- Sub-module `sprite_scan`:
  - 8-bit row/col counter with `start`, `busy`, `done`.
  - Emits offset col[3:0], row[3:0]; `done` asserts on the 256th pixel.
  - Used for both erase and draw.
- Shadow store: 16 × (9+8+1) registers, not RAM.

## Test plan
- Reset, enable=1, quantity=1, record x=100, y=50, type=01, visible=1:
  - After `FRAME_CLOCK` cycles, 256 plots with colour 3'b110 covering x 100..115, y 50..65.
  - `draw_stone_flag` high for 261 cycles.
- Same record next pass with x=106:
  - 256 erase plots at x 100..115 with 3'b000, then 256 draws at x 106..121.
- Record x=310, y=230, visible:
  - Exactly 100 plots; none with x ≥ 320 or y ≥ 240.
- quantity=3, record 1 visible=0 never drawn:
  - Plots only for records 0 and 2.
  - `draw_index` visits 0, 1, 2 in order.
- Drawn stone then visible cleared:
  - Next pass emits 256 erase plots only; the following pass emits none for that slot.
- Assert `reset` during S_DRAW:
  - `plot`=0 and `draw_stone_flag`=0 after the edge.
  - The next pass redraws without erasing, because the shadow was cleared.
